// File: rtl/pong_pkg.sv
// Shared vPong constants and FSM encodings for the score, digit and ball blocks.
package pong_pkg;

  localparam int unsigned SCORE_W         = 4;
  localparam int unsigned MAX_DIGIT       = 9;
  localparam int unsigned HOLD_W          = 8;
  localparam int unsigned STATE_W         = 2;
  localparam int unsigned WIN_SCORE_DEF   = 7;
  localparam int unsigned HOLD_FRAMES_DEF = 60;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2,
    ST_OVER = 2'd3
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse when a level input goes from low to high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse_c
);

  logic level_q;

  // Previous-cycle copy of the level, updated every cycle.
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse_c = level & ~level_q;

endmodule

// File: rtl/score_keeper.sv
// vPong match controller: goal edges to decimal scores, serve hold and game-over freeze.
module score_keeper
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               goal1,
  input  logic               goal2,
  output logic [SCORE_W-1:0] point1,
  output logic [SCORE_W-1:0] point2,
  output logic               ball_run,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  localparam int unsigned HOLD_MAX = (1 << HOLD_W) - 1;

  // Reject parameter values that do not fit one display digit or the hold counter.
  if (WIN_SCORE < 1 || WIN_SCORE > MAX_DIGIT) begin : g_bad_win_score
    $error("score_keeper: WIN_SCORE must be 1..9");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > HOLD_MAX) begin : g_bad_hold_frames
    $error("score_keeper: HOLD_FRAMES must be 1..255");
  end

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  state_e             state;
  state_e             state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_nxt;
  logic [SCORE_W-1:0] point1_nxt;
  logic [SCORE_W-1:0] point2_nxt;
  logic               serve_dir_nxt;
  logic               winner_nxt;
  logic               ball_run_nxt;
  logic               game_over_nxt;

  logic               goal1_rise_c;
  logic               goal2_rise_c;
  logic               start_rise_c;
  logic [SCORE_W-1:0] point1_inc_c;
  logic [SCORE_W-1:0] point2_inc_c;

  rise_detect u_goal1_rise (
    .clk     (clk),
    .reset   (reset),
    .level   (goal1),
    .pulse_c (goal1_rise_c)
  );

  rise_detect u_goal2_rise (
    .clk     (clk),
    .reset   (reset),
    .level   (goal2),
    .pulse_c (goal2_rise_c)
  );

  rise_detect u_start_rise (
    .clk     (clk),
    .reset   (reset),
    .level   (start),
    .pulse_c (start_rise_c)
  );

  assign point1_inc_c = point1 + SCORE_W'(1);
  assign point2_inc_c = point2 + SCORE_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; simultaneous goals count for nobody but still force a re-serve.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_rise_c) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (goal1_rise_c && goal2_rise_c) state_nxt = ST_HOLD;
        else if (goal1_rise_c)            state_nxt = (point1_inc_c == WIN_VAL) ? ST_OVER : ST_HOLD;
        else if (goal2_rise_c)            state_nxt = (point2_inc_c == WIN_VAL) ? ST_OVER : ST_HOLD;
      end
      ST_HOLD: begin
        if (frame_tick && (hold_cnt == HOLD_LAST)) state_nxt = ST_PLAY;
      end
      ST_OVER: begin
        if (start_rise_c) state_nxt = ST_PLAY;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and hold counter.
  always_comb begin
    point1_nxt    = point1;
    point2_nxt    = point2;
    serve_dir_nxt = serve_dir;
    winner_nxt    = winner;
    hold_cnt_nxt  = hold_cnt;
    unique case (state)
      ST_IDLE: begin
        if (start_rise_c) begin
          point1_nxt = '0;
          point2_nxt = '0;
        end
      end
      ST_PLAY: begin
        hold_cnt_nxt = '0;
        if (goal1_rise_c && !goal2_rise_c) begin
          point1_nxt    = point1_inc_c;
          serve_dir_nxt = 1'b1;
          if (point1_inc_c == WIN_VAL) winner_nxt = 1'b0;
        end else if (goal2_rise_c && !goal1_rise_c) begin
          point2_nxt    = point2_inc_c;
          serve_dir_nxt = 1'b0;
          if (point2_inc_c == WIN_VAL) winner_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (frame_tick) begin
          if (hold_cnt == HOLD_LAST) hold_cnt_nxt = '0;
          else                       hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_OVER: begin
        if (start_rise_c) begin
          point1_nxt    = '0;
          point2_nxt    = '0;
          serve_dir_nxt = 1'b0;
        end
      end
      default: begin
        hold_cnt_nxt = '0;
      end
    endcase
    ball_run_nxt  = (state_nxt == ST_PLAY);
    game_over_nxt = (state_nxt == ST_OVER);
  end

  // Output and hold-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      point1    <= '0;
      point2    <= '0;
      ball_run  <= 1'b0;
      serve_dir <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      point1    <= point1_nxt;
      point2    <= point2_nxt;
      ball_run  <= ball_run_nxt;
      serve_dir <= serve_dir_nxt;
      game_over <= game_over_nxt;
      winner    <= winner_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed match scenarios then random play against a match model.
module tb_score_keeper;

  localparam int WIN  = 7;
  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       goal1;
  logic       goal2;
  logic [3:0] point1;
  logic [3:0] point2;
  logic       ball_run;
  logic       serve_dir;
  logic       game_over;
  logic       winner;

  int n_checks = 0;
  int n_fail   = 0;

  // Match model: who is playing, frames left in the serve freeze, scores.
  bit m_active;
  bit m_over;
  int m_hold_left;
  int m_score[2];
  bit m_serve;
  bit m_winner;
  bit m_prev_start;
  bit m_prev_g1;
  bit m_prev_g2;

  score_keeper #(.WIN_SCORE(WIN), .HOLD_FRAMES(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .goal1      (goal1),
    .goal2      (goal2),
    .point1     (point1),
    .point2     (point2),
    .ball_run   (ball_run),
    .serve_dir  (serve_dir),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_over = 0; m_hold_left = 0;
    m_score[0] = 0; m_score[1] = 0;
    m_serve = 0; m_winner = 0;
    m_prev_start = 0; m_prev_g1 = 0; m_prev_g2 = 0;
  endtask

  // A goal for player p (0 or 1) while the ball is live.
  task automatic model_goal(input int p);
    m_score[p]++;
    m_serve = (p == 0);
    if (m_score[p] == WIN) begin
      m_over   = 1;
      m_active = 0;
      m_winner = (p == 1);
    end else begin
      m_hold_left = HOLD;
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit g1, input bit g2, input bit t);
    bit rs, r1, r2;
    if (r) begin
      model_clear();
      return;
    end
    rs = s && !m_prev_start;
    r1 = g1 && !m_prev_g1;
    r2 = g2 && !m_prev_g2;
    m_prev_start = s; m_prev_g1 = g1; m_prev_g2 = g2;
    if (m_over) begin
      if (rs) begin
        m_over = 0; m_active = 1; m_serve = 0;
        m_score[0] = 0; m_score[1] = 0;
      end
    end else if (!m_active) begin
      if (rs) begin
        m_active = 1;
        m_score[0] = 0; m_score[1] = 0;
      end
    end else if (m_hold_left > 0) begin
      if (t) m_hold_left--;
    end else begin
      if (r1 && r2)  m_hold_left = HOLD;
      else if (r1)   model_goal(0);
      else if (r2)   model_goal(1);
    end
  endtask

  task automatic compare_all();
    check("point1",    int'(point1),    m_score[0]);
    check("point2",    int'(point2),    m_score[1]);
    check("ball_run",  int'(ball_run),  int'(m_active && !m_over && m_hold_left == 0));
    check("serve_dir", int'(serve_dir), int'(m_serve));
    check("game_over", int'(game_over), int'(m_over));
    check("winner",    int'(winner),    int'(m_winner));
  endtask

  // Drive one cycle of inputs, advance model on the edge, compare just after it.
  task automatic step(input bit r, input bit s, input bit g1, input bit g2, input bit t);
    @(negedge clk);
    reset = r; start = s; goal1 = g1; goal2 = g2; frame_tick = t;
    @(posedge clk);
    model_step(r, s, g1, g2, t);
    #1;
    compare_all();
  endtask

  initial begin
    bit s, g1, g2;
    reset = 1'b1; start = 1'b0; goal1 = 1'b0; goal2 = 1'b0; frame_tick = 1'b0;
    model_clear();

    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_ball_run", int'(ball_run), 0);

    // Start held high: enters play once, scores zero.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
    check("start_ball_run", int'(ball_run), 1);
    step(0, 0, 0, 0, 0);

    // Goal1 held high for 20 cycles scores exactly once; freeze for three frames.
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, (i % 4) == 3);
    check("goal1_once", int'(point1), 1);
    check("goal1_serve", int'(serve_dir), 1);
    step(0, 0, 0, 0, 0);
    check("hold_released", int'(ball_run), 1);

    // Simultaneous goals: no score, hold, serve direction kept.
    step(0, 0, 1, 1, 0);
    check("tie_p1", int'(point1), 1);
    check("tie_p2", int'(point2), 0);
    check("tie_hold", int'(ball_run), 0);
    check("tie_serve", int'(serve_dir), 1);
    for (int i = 0; i < HOLD; i++) step(0, 0, 0, 0, 1);
    check("tie_release", int'(ball_run), 1);

    // Player 2 wins the match.
    for (int k = 0; k < WIN; k++) begin
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      if (k < WIN - 1) for (int i = 0; i < HOLD; i++) step(0, 0, 0, 0, 1);
    end
    check("win_p2", int'(point2), 7);
    check("win_over", int'(game_over), 1);
    check("win_winner", int'(winner), 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("frozen_p1", int'(point1), 1);
    check("frozen_p2", int'(point2), 7);

    // Restart from game over skips the hold.
    step(0, 1, 0, 0, 0);
    check("restart_p2", int'(point2), 0);
    check("restart_over", int'(game_over), 0);
    check("restart_run", int'(ball_run), 1);
    check("restart_serve", int'(serve_dir), 0);
    step(0, 0, 0, 0, 0);

    // Reset mid-hold with a goal rising on the same edge.
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0);
    check("rst_p1", int'(point1), 0);
    check("rst_serve", int'(serve_dir), 0);
    check("rst_run", int'(ball_run), 0);
    step(0, 0, 1, 0, 1);
    check("rst_idle", int'(ball_run), 0);

    // Random play.
    s = 0; g1 = 1; g2 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) s  = ~s;
      if ($urandom_range(0, 5) == 0) g1 = ~g1;
      if ($urandom_range(0, 5) == 0) g2 = ~g2;
      step($urandom_range(0, 299) == 0, s, g1, g2, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
